// File: rtl/aesl_deadlock_aggregator.sv
// Aggregates per-instance deadlock monitor block flags, filters transient stalls
// with a per-monitor persistence counter, and latches a sticky deadlock report.

module aesl_deadlock_lane #(
  parameter int THRESH = 1000,
  parameter int CNT_W  = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic mon,
  input  logic kill,
  output logic counted,
  output logic hit
);
  logic [CNT_W-1:0] cnt;

  assign counted = mon & ~kill;
  assign hit     = counted & (cnt == CNT_W'(THRESH - 1));

  // Saturates at THRESH so a stall held across FOUND cannot wrap and re-hit.
  always_ff @(posedge clock) begin
    if (reset || !counted)          cnt <= '0;
    else if (cnt != CNT_W'(THRESH)) cnt <= cnt + 1'b1;
  end
endmodule

module aesl_deadlock_aggregator #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2,
  parameter int THRESH  = 1000,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               design_idle,
  input  logic               clear,
  output logic               watching,
  output logic               deadlock_found,
  output logic [IDX_W-1:0]   deadlock_idx,
  output logic [NUM_MON-1:0] deadlock_mask,
  output logic [CNT_W-1:0]   cycle_stamp
);
  typedef enum logic [1:0] {IDLE, WATCH, FOUND} state_t;

  state_t             state;
  logic [CNT_W-1:0]   free_cnt;
  logic [NUM_MON-1:0] hit, counted;
  logic               kill, any_hit, any_cnt;
  logic [IDX_W-1:0]   low_idx;

  assign kill    = design_idle | clear;
  assign any_hit = |hit;
  assign any_cnt = |counted;

  for (genvar g = 0; g < NUM_MON; g++) begin : g_lane
    aesl_deadlock_lane #(.THRESH(THRESH), .CNT_W(CNT_W)) u_lane (
      .clock   (clock),
      .reset   (reset),
      .mon     (mon_block[g]),
      .kill    (kill),
      .counted (counted[g]),
      .hit     (hit[g])
    );
  end

  // Scan downward so the lowest hitting monitor wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--)
      if (hit[i]) low_idx = IDX_W'(i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      free_cnt       <= '0;
      watching       <= 1'b0;
      deadlock_found <= 1'b0;
      deadlock_idx   <= '0;
      deadlock_mask  <= '0;
      cycle_stamp    <= '0;
    end else begin
      free_cnt <= free_cnt + 1'b1;
      case (state)
        IDLE, WATCH: begin
          if (any_hit) begin
            state          <= FOUND;
            watching       <= 1'b0;
            deadlock_found <= 1'b1;
            deadlock_idx   <= low_idx;
            deadlock_mask  <= hit;
            cycle_stamp    <= free_cnt;
          end else if (any_cnt) begin
            state    <= WATCH;
            watching <= 1'b1;
          end else begin
            state    <= IDLE;
            watching <= 1'b0;
          end
        end
        FOUND: begin
          // Report stays frozen until an explicit clear; design_idle is ignored.
          if (clear) begin
            state          <= IDLE;
            deadlock_found <= 1'b0;
            deadlock_idx   <= '0;
            deadlock_mask  <= '0;
            cycle_stamp    <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          watching <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aesl_deadlock_aggregator.sv
// Directed bench for aesl_deadlock_aggregator with NUM_MON=4, THRESH=4.

module tb_aesl_deadlock_aggregator;
  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  mon_block;
  logic        design_idle;
  logic        clear;
  logic        watching;
  logic        deadlock_found;
  logic [1:0]  deadlock_idx;
  logic [3:0]  deadlock_mask;
  logic [15:0] cycle_stamp;

  int checks = 0;
  int errors = 0;

  aesl_deadlock_aggregator #(.NUM_MON(4), .IDX_W(2), .THRESH(4), .CNT_W(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .mon_block      (mon_block),
    .design_idle    (design_idle),
    .clear          (clear),
    .watching       (watching),
    .deadlock_found (deadlock_found),
    .deadlock_idx   (deadlock_idx),
    .deadlock_mask  (deadlock_mask),
    .cycle_stamp    (cycle_stamp)
  );

  always #5 clock = ~clock;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic w, input logic f,
                         input logic [1:0] idx, input logic [3:0] mask, input logic [15:0] st);
    chk({tag, ".watching"}, 32'(watching), 32'(w));
    chk({tag, ".found"},    32'(deadlock_found), 32'(f));
    chk({tag, ".idx"},      32'(deadlock_idx), 32'(idx));
    chk({tag, ".mask"},     32'(deadlock_mask), 32'(mask));
    chk({tag, ".stamp"},    32'(cycle_stamp), 32'(st));
  endtask

  initial begin
    reset = 1'b1; mon_block = '0; design_idle = 1'b0; clear = 1'b0;
    step(2);
    chk_all("reset", 0, 0, 0, 4'h0, 16'd0);

    // 1: single stall on bit 2; free count values seen at edges are 0,1,2,3
    reset = 1'b0; mon_block = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1.watch", 32'(watching), 1);
      chk("t1.nofound", 32'(deadlock_found), 0);
    end
    step();
    chk_all("t1.found", 0, 1, 2'd2, 4'b0100, 16'd3);

    mon_block = '0; clear = 1'b1; step(); clear = 1'b0;       // F=4
    chk_all("t1.clr", 0, 0, 0, 4'h0, 16'd0);

    // 2: burst of 3, one low sample, then 4 highs on bit 1
    mon_block = 4'b0010; step(3);                              // F=5..7
    chk("t2.burst.watch", 32'(watching), 1);
    chk("t2.burst.nofound", 32'(deadlock_found), 0);
    mon_block = '0; step();                                    // F=8
    chk("t2.gap.watch", 32'(watching), 0);
    mon_block = 4'b0010; step(3);                              // F=9..11
    chk("t2.pre.nofound", 32'(deadlock_found), 0);
    step();                                                    // F=12
    chk_all("t2.found", 0, 1, 2'd1, 4'b0010, 16'd12);
    mon_block = '0; clear = 1'b1; step(); clear = 1'b0;       // F=13

    // 3: two monitors stall together
    mon_block = 4'b1010; step(3);                              // F=14..16
    chk("t3.pre.nofound", 32'(deadlock_found), 0);
    step();                                                    // F=17
    chk_all("t3.found", 0, 1, 2'd1, 4'b1010, 16'd17);

    // 4: frozen while FOUND, design_idle does not leave it; then clear and re-detect
    mon_block = '0; design_idle = 1'b1; step(2);               // F=18,19
    chk_all("t4.frozen", 0, 1, 2'd1, 4'b1010, 16'd17);
    design_idle = 1'b0; clear = 1'b1; step(); clear = 1'b0;    // F=20
    chk_all("t4.clr", 0, 0, 0, 4'h0, 16'd0);
    mon_block = 4'b0001; step(3);                              // F=21..23
    chk("t4.pre.nofound", 32'(deadlock_found), 0);
    step();                                                    // F=24
    chk_all("t4.found", 0, 1, 2'd0, 4'b0001, 16'd24);

    // 5: clear on the would-be hit edge wins
    mon_block = '0; clear = 1'b1; step(); clear = 1'b0;       // F=25
    mon_block = 4'b0100; step(3);                              // F=26..28, cnt=3
    clear = 1'b1; step(); clear = 1'b0;                        // F=29
    chk_all("t5.clrhit", 0, 0, 0, 4'h0, 16'd0);
    step(3);                                                   // F=30..32
    chk("t5.rewatch", 32'(watching), 1);
    chk("t5.pre.nofound", 32'(deadlock_found), 0);
    step();                                                    // F=33
    chk_all("t5.found", 0, 1, 2'd2, 4'b0100, 16'd33);

    // 6: reset mid-WATCH restarts counters
    mon_block = '0; clear = 1'b1; step(); clear = 1'b0;
    mon_block = 4'b0001; step(2);
    chk("t6.watch", 32'(watching), 1);
    reset = 1'b1; step();
    chk_all("t6.rst_watch", 0, 0, 0, 4'h0, 16'd0);
    reset = 1'b0; step(3);
    chk("t6.restart.watch", 32'(watching), 1);
    chk("t6.restart.nofound", 32'(deadlock_found), 0);
    step();
    chk("t6.restart.found", 32'(deadlock_found), 1);

    // reset mid-FOUND, with clear also high to confirm reset priority
    clear = 1'b1; reset = 1'b1; step(); clear = 1'b0;
    chk_all("t6.rst_found", 0, 0, 0, 4'h0, 16'd0);

    // design_idle masks every monitor; free counter restarts from 0 after reset
    reset = 1'b0; design_idle = 1'b1; mon_block = 4'b1111;
    for (int i = 0; i < 10; i++) begin                         // F=0..9
      step();
      chk("t6.idle.watch", 32'(watching), 0);
      chk("t6.idle.found", 32'(deadlock_found), 0);
    end
    design_idle = 1'b0; step(3);                               // F=10..12
    chk("t6.all.nofound", 32'(deadlock_found), 0);
    step();                                                    // F=13
    chk_all("t6.all.found", 0, 1, 2'd0, 4'b1111, 16'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
